// File: rtl/game_fsm_np.sv
// Turn-based controller for the robot-zap game: table selection, per-game switch usage,
// player rotation and framed 16-bit status messages to the UART TX path over valid/ready.
module game_fsm_np #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_TABLES   = 8,
    parameter int NUM_SWITCHES = 8,
    parameter int MAX_TURNS    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_c,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        res_valid,
    input  logic        res_win,
    output logic [15:0] msg_data,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic [2:0]  state_o,
    output logic [2:0]  cur_player,
    output logic [2:0]  cursor,
    output logic [5:0]  table_sel,
    output logic [5:0]  turn_cnt
);

    typedef enum logic [2:0] {
        S_INIT       = 3'b000,
        S_MENU       = 3'b001,
        S_SEND_SETUP = 3'b011,
        S_TURN       = 3'b010,
        S_SEND_MOVE  = 3'b110,
        S_CHECK      = 3'b111,
        S_SEND_END   = 3'b101,
        S_GAMEEND    = 3'b100
    } state_t;

    localparam logic [5:0] LP_TBL_LAST  = 6'(NUM_TABLES - 1);
    localparam logic [2:0] LP_SW_LAST   = 3'(NUM_SWITCHES - 1);
    localparam logic [2:0] LP_PL_LAST   = 3'(NUM_PLAYERS - 1);
    localparam logic [5:0] LP_MAX_TURNS = 6'(MAX_TURNS);
    localparam logic [7:0] LP_SW_MASK   = 8'((1 << NUM_SWITCHES) - 1);
    localparam logic [2:0] LP_DRAW      = 3'd7;

    // Message word: type, A, C, D, zero, then even parity over bits 15..1.
    function automatic logic [15:0] f_msg(input logic [1:0] typ, input logic [5:0] a,
                                          input logic [2:0] c, input logic [2:0] d);
        logic [15:0] w_word;
        w_word    = {typ, a, c, d, 2'b00};
        w_word[0] = ^w_word[15:1];
        return w_word;
    endfunction

    state_t      r_state, w_state_next;
    logic [5:0]  r_table_sel, w_table_next;
    logic [2:0]  r_player, w_player_next;
    logic [2:0]  r_cursor, w_cursor_next;
    logic [5:0]  r_turn_cnt, w_turn_next;
    logic [7:0]  r_used, w_used_next;
    logic        r_msg_valid, w_msg_valid_next;
    logic [15:0] r_msg_data, w_msg_data_next;
    logic        w_btn_any;
    logic        w_all_used;
    logic        w_xfer;

    assign w_btn_any  = btn_c | btn_u | btn_d | btn_l | btn_r;
    assign w_all_used = ((r_used | ~LP_SW_MASK) == 8'hFF);
    assign w_xfer     = r_msg_valid & msg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_table_sel <= '0;
            r_player    <= '0;
            r_cursor    <= '0;
            r_turn_cnt  <= '0;
            r_used      <= '0;
            r_msg_valid <= 1'b0;
            r_msg_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_table_sel <= w_table_next;
            r_player    <= w_player_next;
            r_cursor    <= w_cursor_next;
            r_turn_cnt  <= w_turn_next;
            r_used      <= w_used_next;
            r_msg_valid <= w_msg_valid_next;
            r_msg_data  <= w_msg_data_next;
        end
    end

    // msg_valid is registered alongside the state so it rises on the edge entering a SEND state.
    always_comb begin
        w_state_next     = r_state;
        w_table_next     = r_table_sel;
        w_player_next    = r_player;
        w_cursor_next    = r_cursor;
        w_turn_next      = r_turn_cnt;
        w_used_next      = r_used;
        w_msg_valid_next = r_msg_valid;
        w_msg_data_next  = r_msg_data;
        case (r_state)
            S_INIT: begin
                if (w_btn_any) begin
                    w_state_next = S_MENU;
                end else begin
                    w_table_next = (r_table_sel == LP_TBL_LAST) ? 6'd0 : r_table_sel + 6'd1;
                end
            end
            S_MENU: begin
                if (btn_c) begin
                    w_state_next     = S_SEND_SETUP;
                    w_msg_valid_next = 1'b1;
                    w_msg_data_next  = f_msg(2'b01, r_table_sel, 3'd0, LP_PL_LAST);
                end else if (btn_u) begin
                    w_table_next = (r_table_sel == LP_TBL_LAST) ? 6'd0 : r_table_sel + 6'd1;
                end else if (btn_d) begin
                    w_table_next = (r_table_sel == 6'd0) ? LP_TBL_LAST : r_table_sel - 6'd1;
                end
            end
            S_SEND_SETUP: begin
                if (w_xfer) begin
                    w_state_next     = S_TURN;
                    w_msg_valid_next = 1'b0;
                    w_player_next    = 3'd0;
                    w_cursor_next    = 3'd0;
                end
            end
            S_TURN: begin
                // A centre press on an already-used switch consumes the cycle without effect.
                if (btn_c) begin
                    if (!r_used[r_cursor]) begin
                        w_used_next[r_cursor] = 1'b1;
                        w_turn_next           = r_turn_cnt + 6'd1;
                        w_state_next          = S_SEND_MOVE;
                        w_msg_valid_next      = 1'b1;
                        w_msg_data_next       = f_msg(2'b10, r_turn_cnt + 6'd1, r_cursor, r_player);
                    end
                end else if (btn_l) begin
                    w_cursor_next = (r_cursor == 3'd0) ? LP_SW_LAST : r_cursor - 3'd1;
                end else if (btn_r) begin
                    w_cursor_next = (r_cursor == LP_SW_LAST) ? 3'd0 : r_cursor + 3'd1;
                end
            end
            S_SEND_MOVE: begin
                if (w_xfer) begin
                    w_state_next     = S_CHECK;
                    w_msg_valid_next = 1'b0;
                end
            end
            S_CHECK: begin
                if (res_valid) begin
                    if (res_win) begin
                        w_state_next     = S_SEND_END;
                        w_msg_valid_next = 1'b1;
                        w_msg_data_next  = f_msg(2'b11, r_turn_cnt, 3'd0, r_player);
                    end else if ((r_turn_cnt == LP_MAX_TURNS) || w_all_used) begin
                        w_state_next     = S_SEND_END;
                        w_msg_valid_next = 1'b1;
                        w_msg_data_next  = f_msg(2'b11, r_turn_cnt, 3'd0, LP_DRAW);
                    end else begin
                        w_state_next  = S_TURN;
                        w_player_next = (r_player == LP_PL_LAST) ? 3'd0 : r_player + 3'd1;
                    end
                end
            end
            S_SEND_END: begin
                if (w_xfer) begin
                    w_state_next     = S_GAMEEND;
                    w_msg_valid_next = 1'b0;
                end
            end
            S_GAMEEND: begin
                if (btn_c) begin
                    w_state_next  = S_MENU;
                    w_used_next   = '0;
                    w_turn_next   = '0;
                    w_player_next = '0;
                    w_cursor_next = '0;
                end
            end
            default: w_state_next = S_INIT;
        endcase
    end

    assign msg_data   = r_msg_data;
    assign msg_valid  = r_msg_valid;
    assign state_o    = r_state;
    assign cur_player = r_player;
    assign cursor     = r_cursor;
    assign table_sel  = r_table_sel;
    assign turn_cnt   = r_turn_cnt;

endmodule
